// File: rtl/maj3_pkg.sv
// Shared defaults and helpers for the maj3 input conditioner.
// Used by debounce_ch and maj3_input_conditioner.
package maj3_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_ERR_W           = 8;

  // Counter must be able to hold DEBOUNCE_CYCLES-1; never narrower than 1 bit.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: 2-flop synchroniser followed by a
// consecutive-difference debounce counter and the clean output register.
module debounce_ch
  import maj3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic q,
  output logic flip
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // flip is the next-state view: q toggles on the coming edge.
  assign flip = (s2 != q) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      q   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != q) begin
        if (flip) begin
          q   <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/maj3_input_conditioner.sv
// Three debounced channels feeding the majority voter, plus change/disagreement
// reporting. Define MAJ3_VOTE_EN to add the registered f_vote test point.
module maj3_input_conditioner
  import maj3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ERR_W           = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_raw,
  input  logic             b_raw,
  input  logic             c_raw,
  input  logic             clr_err,
  output logic             a_q,
  output logic             b_q,
  output logic             c_q,
  output logic             chg,
  output logic             disagree,
  output logic [ERR_W-1:0] err_cnt
`ifdef MAJ3_VOTE_EN
  ,
  output logic             f_vote
`endif
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic a_flip;
  logic b_flip;
  logic c_flip;

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_a (
    .clk(clk), .rst_n(rst_n), .raw(a_raw), .q(a_q), .flip(a_flip)
  );

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .raw(b_raw), .q(b_q), .flip(b_flip)
  );

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_c (
    .clk(clk), .rst_n(rst_n), .raw(c_raw), .q(c_q), .flip(c_flip)
  );

  logic a_nxt;
  logic b_nxt;
  logic c_nxt;
  logic chg_nxt;
  logic split_nxt;

  // Status is derived from next-state q so it lines up with q every cycle.
  assign a_nxt     = a_q ^ a_flip;
  assign b_nxt     = b_q ^ b_flip;
  assign c_nxt     = c_q ^ c_flip;
  assign chg_nxt   = a_flip | b_flip | c_flip;
  assign split_nxt = !((a_nxt == b_nxt) && (b_nxt == c_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg      <= 1'b0;
      disagree <= 1'b0;
      err_cnt  <= '0;
    end else begin
      chg      <= chg_nxt;
      disagree <= split_nxt;
      if (clr_err) begin
        err_cnt <= '0;
      end else if (chg_nxt && split_nxt && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

`ifdef MAJ3_VOTE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_vote <= 1'b0;
    end else begin
      f_vote <= (a_nxt & b_nxt) | (b_nxt & c_nxt) | (a_nxt & c_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_maj3_input_conditioner.sv
// Scoreboard bench for maj3_input_conditioner: driver pushes predicted outputs
// from a sample-window model, a monitor pops and compares after each edge.
module tb_maj3_input_conditioner;

  localparam int D  = 4;
  localparam int EW = 3;
  localparam int ERR_LIMIT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_raw, b_raw, c_raw, clr_err;
  logic          a_q, b_q, c_q, chg, disagree;
  logic [EW-1:0] err_cnt;
  logic          f_vote_dut;

  always #5 clk = ~clk;

  maj3_input_conditioner #(.DEBOUNCE_CYCLES(D), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw), .clr_err(clr_err),
    .a_q(a_q), .b_q(b_q), .c_q(c_q), .chg(chg), .disagree(disagree),
    .err_cnt(err_cnt)
`ifdef MAJ3_VOTE_EN
    , .f_vote(f_vote_dut)
`endif
  );

`ifndef MAJ3_VOTE_EN
  assign f_vote_dut = 1'b0;
`endif

  typedef struct packed {
    logic          a;
    logic          b;
    logic          c;
    logic          chg;
    logic          dis;
    logic [EW-1:0] err;
    logic          vote;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   running  = 0;

  // Model state: raw samples taken at each edge since reset, and clean levels.
  bit hist_a[$];
  bit hist_b[$];
  bit hist_c[$];
  bit m_a, m_b, m_c;
  int m_err;

  // A channel flips when the synchronised value (raw two edges back) has
  // disagreed with the clean level for each of the last D edges.
  function automatic bit window_differs(input bit h[$], input bit cur);
    int n = h.size();
    for (int j = 0; j < D; j++) begin
      int idx = n - 3 - j;
      bit v   = (idx >= 0) ? h[idx] : 1'b0;
      if (v == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic exp_t model_edge(input bit in_reset, input bit ra, input bit rb,
                                      input bit rc, input bit clr);
    exp_t e;
    bit   fa, fb, fc, split;
    e = '0;
    if (in_reset) begin
      hist_a.delete(); hist_b.delete(); hist_c.delete();
      m_a = 0; m_b = 0; m_c = 0; m_err = 0;
      return e;
    end
    hist_a.push_back(ra); hist_b.push_back(rb); hist_c.push_back(rc);
    if (hist_a.size() > D + 3) begin
      void'(hist_a.pop_front()); void'(hist_b.pop_front()); void'(hist_c.pop_front());
    end
    fa = window_differs(hist_a, m_a);
    fb = window_differs(hist_b, m_b);
    fc = window_differs(hist_c, m_c);
    if (fa) m_a = !m_a;
    if (fb) m_b = !m_b;
    if (fc) m_c = !m_c;
    split = !((m_a == m_b) && (m_b == m_c));
    if (clr) m_err = 0;
    else if ((fa || fb || fc) && split && m_err < ERR_LIMIT) m_err++;
    e.a    = m_a;
    e.b    = m_b;
    e.c    = m_c;
    e.chg  = fa || fb || fc;
    e.dis  = split;
    e.err  = EW'(m_err);
    e.vote = (m_a + m_b + m_c) >= 2;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst_lvl, input bit ra, input bit rb,
                               input bit rc, input bit clr);
    exp_t e;
    @(negedge clk);
    rst_n   = rst_lvl;
    a_raw   = ra;
    b_raw   = rb;
    c_raw   = rc;
    clr_err = clr;
    e = model_edge(!rst_lvl, ra, rb, rc, clr);
    exp_q.push_back(e);
    running = 1;
  endtask

  task automatic holdFor(input int n, input bit ra, input bit rb, input bit rc);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, ra, rb, rc, 1'b0);
  endtask

  // Monitor: every edge after the driver starts must have a prediction waiting.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (running) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("a_q", {7'd0, a_q}, {7'd0, e.a});
        checkOutput("b_q", {7'd0, b_q}, {7'd0, e.b});
        checkOutput("c_q", {7'd0, c_q}, {7'd0, e.c});
        checkOutput("chg", {7'd0, chg}, {7'd0, e.chg});
        checkOutput("disagree", {7'd0, disagree}, {7'd0, e.dis});
        checkOutput("err_cnt", 8'(err_cnt), 8'(e.err));
`ifdef MAJ3_VOTE_EN
        checkOutput("f_vote", {7'd0, f_vote_dut}, {7'd0, e.vote});
`endif
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ra, rb, rc;
    rst_n = 1'b0; a_raw = 0; b_raw = 0; c_raw = 0; clr_err = 0;

    $display("[TB] reset with toggling raws");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    holdFor(4, 0, 0, 0);

    $display("[TB] clean transition on A, then back");
    holdFor(9, 1, 0, 0);
    holdFor(9, 0, 0, 0);

    $display("[TB] glitch on B");
    holdFor(3, 0, 1, 0);
    holdFor(8, 0, 0, 0);

    $display("[TB] simultaneous rise and fall");
    holdFor(9, 1, 1, 1);
    holdFor(9, 0, 0, 0);

    $display("[TB] reset mid-debounce on C");
    holdFor(4, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_c_q", {7'd0, c_q}, 8'd0);
    checkOutput("async_reset_err", 8'(err_cnt), 8'd0);
    exp_q.push_back(model_edge(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    holdFor(9, 0, 0, 1);
    holdFor(9, 0, 0, 0);

    $display("[TB] random phase without clears");
    ra = 0; rb = 0; rc = 0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(4) == 0) ra = !ra;
      if ($urandom_range(4) == 0) rb = !rb;
      if ($urandom_range(4) == 0) rc = !rc;
      applyStimulus(1'b1, ra, rb, rc, 1'b0);
    end

    $display("[TB] random phase with clears and resets");
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(5) == 0) ra = !ra;
      if ($urandom_range(5) == 0) rb = !rb;
      if ($urandom_range(5) == 0) rc = !rc;
      applyStimulus(($urandom_range(300) != 0), ra, rb, rc, ($urandom_range(25) == 0));
    end

    holdFor(10, 0, 0, 0);
    @(negedge clk);
    running = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maj3_input_conditioner.md
Name: maj3_input_conditioner

Overview:
- Upstream front-end for the 3-input majority voter. Takes three raw, asynchronous, possibly bouncy inputs (switches or redundant sensors).
- Synchronises and debounces each channel, then presents clean levels a_q/b_q/c_q directly to the majority gate.
- Also reports channel disagreement: a flag plus a saturating count, for lab observation of voter masking.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clock edges a synchronised channel must differ from its output before the output flips; legal range >=1.
- ERR_W, 8, width of the saturating disagreement counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_raw  input  1  raw channel A, asynchronous to clk.
- b_raw  input  1  raw channel B, asynchronous to clk.
- c_raw  input  1  raw channel C, asynchronous to clk.
- clr_err  input  1  synchronous clear of err_cnt.
- a_q  output  1  debounced A, to voter input A.
- b_q  output  1  debounced B, to voter input B.
- c_q  output  1  debounced C, to voter input C.
- chg  output  1  one-cycle pulse: at least one of a_q/b_q/c_q changed on this edge.
- disagree  output  1  a_q/b_q/c_q not all equal.
- err_cnt  output  ERR_W  saturating count of non-unanimous updates.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, a_q/b_q/c_q, debounce counters, chg, disagree and err_cnt go to 0. Removal is sampled at the clk edge.
- Per channel, identical logic:
  - 2-flop synchroniser s1 -> s2.
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - On each edge with s2 != q: if cnt == DEBOUNCE_CYCLES-1 then q <= s2 and cnt <= 0; else cnt <= cnt+1.
  - On each edge with s2 == q: cnt <= 0. Any glitch restarts the count.
- Latency: raw value stable from before edge n appears on q after edge n+DEBOUNCE_CYCLES+1.
  - Pulses shorter than DEBOUNCE_CYCLES clocks at s2 never reach q.
- DEBOUNCE_CYCLES=1: q follows s2 with one extra edge; there is no filtering beyond synchronisation.
- chg: registered; 1 on exactly the edge any q updates, 0 otherwise. Simultaneous flips of several channels produce one single-cycle chg.
- disagree: registered; equals NOT(a_q==b_q==c_q) computed on the next-state values, so it is coherent with q every cycle.
- err_cnt update priority:
  - clr_err=1 -> 0.
  - Else, if chg next-state is 1 and the new triple is non-unanimous -> increments by 1, saturating at 2^ERR_W-1 (no wrap).
  - Else holds.
- Simultaneous clr_err and a counting update: clear wins; that update is not counted.
- Reset mid-debounce: partial counts are discarded; after release, each channel restarts from q=0.

Optional Feature:
- Macro MAJ3_VOTE_EN.
- Defined: adds output port f_vote (1 bit) = (a_q&b_q)|(b_q&c_q)|(a_q&c_q), registered on the same edge as q, reset 0, for a self-contained test point.
- Undefined: port and logic absent. The external NAND majority gate is the only voter.

Decomposition:
- Shared package/include maj3_pkg:
  - DEBOUNCE_CYCLES default.
  - ERR_W default.
  - Localparam function for the counter width.
- One natural sub-module: debounce_ch, holding synchroniser + counter + q register with ports clk, rst_n, raw, q, flip. Instantiated three times; the top holds chg/disagree/err_cnt logic.

Test Plan:
- Reset: hold rst_n=0 with raws toggling -> all outputs 0. Release -> outputs stay 0 while raws are 0.
- Clean transition, D=4: a_raw 0->1 before edge 10 and held -> a_q=1 and chg=1 after edge 15. chg=0 at edge 16. disagree=1 and err_cnt=1 after edge 15.
- Glitch rejection, D=4: b_raw high for 3 clocks then low -> b_q stays 0, chg never asserts, err_cnt unchanged.
- Simultaneous: a_raw, b_raw, c_raw all 0->1 together -> all q rise on the same edge, one chg pulse, disagree=0, err_cnt unchanged.
- Saturation/clear, ERR_W=2: create 5 non-unanimous updates -> err_cnt sticks at 3. Assert clr_err on the edge of a 6th update -> err_cnt=0.
- Reset mid-debounce: c_raw rises, rst_n pulsed low after 2 clocks of counting -> c_q=0. After release it rises DEBOUNCE_CYCLES+2 edges later. With MAJ3_VOTE_EN, f_vote tracks the majority of the q's each cycle.
